tow_referee: RTL and testbench

- Round/match referee sitting directly downstream of the 16-bit board shifter; consumes its one-hot board vector every cycle.
- Detects the marker reaching an end lamp, awards the point, freezes play, holds the win display, then pulses a one-cycle round reset back to the shifter.
- Keeps per-player scores and declares the match winner at MAX_SCORE.

---
 rtl/tow_referee.sv | 162 ++++++++++++++++
 tb/tb_tow_referee.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tow_referee.sv
// Round/match referee for the tug-of-war board; optional 7-seg score outputs under TOW_REFEREE_SEG_EN.
// Latency: a board condition sampled in cycle N shows on the registered outputs in cycle N+1.
// Backpressure: o_freeze holds the upstream shifter still outside PLAY; o_round_reset is a single-cycle restart pulse.
module tow_referee #(
    parameter int WIDTH       = 16,
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_brd_array,
    input  logic             i_new_match,
    output logic             o_round_reset,
    output logic             o_freeze,
    output logic [1:0]       o_winner,
    output logic [3:0]       o_left_score,
    output logic [3:0]       o_right_score,
    output logic             o_match_over
`ifdef TOW_REFEREE_SEG_EN
    ,
    output logic [6:0]       o_hex_left,
    output logic [6:0]       o_hex_right
`endif
);

    typedef enum logic [1:0] {S_PLAY, S_HOLD, S_ROUND_RST, S_OVER} state_t;

    localparam int            CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    MAX_S     = 4'(MAX_SCORE);

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [1:0]    r_winner, w_winner_nxt;
    logic [3:0]    r_left_score, w_left_nxt;
    logic [3:0]    r_right_score, w_right_nxt;
    logic          r_round_reset, r_freeze, r_match_over;
    logic          w_left_end, w_right_end, w_at_max;

    // Assertion is immediate; release is retimed to i_clk.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_left_end  = i_brd_array[WIDTH-1];
    assign w_right_end = i_brd_array[0];
    assign w_at_max    = (r_left_score == MAX_S) || (r_right_score == MAX_S);

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = '0;
        w_winner_nxt   = r_winner;
        w_left_nxt     = r_left_score;
        w_right_nxt    = r_right_score;
        case (r_state)
            S_PLAY: begin
                if (w_left_end && !w_right_end) begin
                    w_state_nxt  = S_HOLD;
                    w_winner_nxt = 2'b10;
                    if (r_left_score < MAX_S) w_left_nxt = r_left_score + 4'd1;
                end else if (w_right_end && !w_left_end) begin
                    w_state_nxt  = S_HOLD;
                    w_winner_nxt = 2'b01;
                    if (r_right_score < MAX_S) w_right_nxt = r_right_score + 4'd1;
                end else if (w_left_end && w_right_end) begin
                    w_state_nxt  = S_HOLD;
                    w_winner_nxt = 2'b11;
                end else if (i_brd_array == '0) begin
                    w_state_nxt  = S_ROUND_RST;
                    w_winner_nxt = 2'b11;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = w_at_max ? S_OVER : S_ROUND_RST;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CW'(1);
                end
            end
            S_ROUND_RST: begin
                w_state_nxt  = S_PLAY;
                w_winner_nxt = 2'b00;
            end
            S_OVER: begin
                if (i_new_match) begin
                    w_state_nxt = S_ROUND_RST;
                    w_left_nxt  = 4'd0;
                    w_right_nxt = 4'd0;
                end
            end
            default: w_state_nxt = S_PLAY;
        endcase
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= S_PLAY;
            r_hold_cnt    <= '0;
            r_winner      <= 2'b00;
            r_left_score  <= 4'd0;
            r_right_score <= 4'd0;
            r_round_reset <= 1'b0;
            r_freeze      <= 1'b0;
            r_match_over  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_winner      <= w_winner_nxt;
            r_left_score  <= w_left_nxt;
            r_right_score <= w_right_nxt;
            r_round_reset <= (w_state_nxt == S_ROUND_RST);
            r_freeze      <= (w_state_nxt != S_PLAY);
            r_match_over  <= (w_state_nxt == S_OVER);
        end
    end

    assign o_round_reset = r_round_reset;
    assign o_freeze      = r_freeze;
    assign o_winner      = r_winner;
    assign o_left_score  = r_left_score;
    assign o_right_score = r_right_score;
    assign o_match_over  = r_match_over;

`ifdef TOW_REFEREE_SEG_EN
    // Active-low segments, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [6:0] r_hex_left, r_hex_right;

    // In OVER only the side that reached MAX_SCORE keeps its digit lit.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hex_left  <= 7'b1000000;
            r_hex_right <= 7'b1000000;
        end else begin
            r_hex_left  <= (r_state == S_OVER && r_left_score != MAX_S)  ? 7'h7F : seg7(r_left_score);
            r_hex_right <= (r_state == S_OVER && r_right_score != MAX_S) ? 7'h7F : seg7(r_right_score);
        end
    end

    assign o_hex_left  = r_hex_left;
    assign o_hex_right = r_hex_right;
`endif

endmodule

// File: tb/tb_tow_referee.sv
// Self-checking bench for tow_referee: directed and random rounds against a round-level expected trace.
module tb_tow_referee;
    localparam int W     = 16;
    localparam int MAXS  = 7;
    localparam int HOLDC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] brd = 16'h0100;
    logic         new_match = 1'b0;
    logic         round_reset, freeze, match_over;
    logic [1:0]   winner;
    logic [3:0]   left_score, right_score;
`ifdef TOW_REFEREE_SEG_EN
    logic [6:0]   hex_left, hex_right;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int el = 0;
    int er = 0;

    logic [15:0] dir_tab [13] = '{16'h8000, 16'h8001, 16'h0000, 16'h0FF0, 16'h0100,
                                  16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
                                  16'h0001, 16'h0001, 16'h4002};

    tow_referee #(.WIDTH(W), .MAX_SCORE(MAXS), .HOLD_CYCLES(HOLDC)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_brd_array(brd), .i_new_match(new_match),
        .o_round_reset(round_reset), .o_freeze(freeze), .o_winner(winner),
        .o_left_score(left_score), .o_right_score(right_score), .o_match_over(match_over)
`ifdef TOW_REFEREE_SEG_EN
        , .o_hex_left(hex_left), .o_hex_right(hex_right)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] obs();
        return {round_reset, freeze, winner, left_score, right_score, match_over};
    endfunction

    function automatic logic [12:0] expv(bit rr, bit fr, logic [1:0] w, int l, int r, bit mo);
        return {rr, fr, w, 4'(l), 4'(r), mo};
    endfunction

    function automatic logic [15:0] interior();
        logic [15:0] v;
        v = 16'($urandom);
        v[15] = 1'b0;
        v[0]  = 1'b0;
        v[8]  = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        brd   = 16'h0100;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs() !== expv(0, 0, 2'b00, 0, 0, 0))
            $display("FAIL reset_values: got %b want %b", obs(), expv(0, 0, 2'b00, 0, 0, 0));
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (obs() !== expv(0, 0, 2'b00, 0, 0, 0))
                $display("FAIL idle_play cyc %0d: got %b want %b", i, obs(), expv(0, 0, 2'b00, 0, 0, 0));
            else n_pass++;
            if (i < 9) @(negedge clk);
        end
        el = 0;
        er = 0;
    endtask

    // Each round: drive one board, build the expected per-cycle trace from the rules, then replay and compare.
    task automatic test_rounds();
        logic [15:0] b;
        logic [1:0]  ew;
        logic [12:0] exq[$];
        logic [16:0] inq[$];
        logic        nm;
        for (int rnd = 0; rnd < 53; rnd++) begin
            if (rnd < 13) b = dir_tab[rnd];
            else begin
                case ($urandom_range(0, 5))
                    0:       b = interior() | 16'h8000;
                    1:       b = interior() | 16'h0001;
                    2:       b = interior() | 16'h8001;
                    3:       b = 16'h0000;
                    4:       b = interior();
                    default: b = 16'($urandom);
                endcase
            end
            exq.delete();
            inq.delete();
            brd       = b;
            new_match = 1'($urandom);
            @(negedge clk);
            new_match = 1'b0;
            if (b[15] || b[0]) begin
                if (b[15] && b[0]) ew = 2'b11;
                else if (b[15]) begin ew = 2'b10; if (el < MAXS) el++; end
                else begin ew = 2'b01; if (er < MAXS) er++; end
                for (int k = 0; k < HOLDC; k++) begin
                    exq.push_back(expv(0, 1, ew, el, er, 0));
                    inq.push_back({1'b0, interior()});
                end
                if (el == MAXS || er == MAXS) begin
                    for (int k = 0; k < 4; k++) begin
                        nm = (k == 3);
                        exq.push_back(expv(0, 1, ew, el, er, 1));
                        inq.push_back({nm, (k == 0) ? 16'h8000 : 16'($urandom)});
                    end
                    el = 0;
                    er = 0;
                end
                exq.push_back(expv(1, 1, ew, el, er, 0));
                inq.push_back({1'b0, interior()});
                exq.push_back(expv(0, 0, 2'b00, el, er, 0));
                inq.push_back(17'h0);
            end else if (b == 16'h0000) begin
                exq.push_back(expv(1, 1, 2'b11, el, er, 0));
                inq.push_back({1'b0, interior()});
                exq.push_back(expv(0, 0, 2'b00, el, er, 0));
                inq.push_back(17'h0);
            end else begin
                exq.push_back(expv(0, 0, 2'b00, el, er, 0));
                inq.push_back(17'h0);
            end
            for (int i = 0; i < exq.size(); i++) begin
                n_checks++;
                if (obs() !== exq[i])
                    $display("FAIL round %0d brd=%h step %0d: got %b want %b", rnd, b, i, obs(), exq[i]);
                else n_pass++;
                if (i < exq.size() - 1) begin
                    {new_match, brd} = inq[i];
                    @(negedge clk);
                end
            end
            new_match = 1'b0;
        end
    endtask

    task automatic test_reset_mid_hold();
        brd = 16'h8000;
        @(negedge clk);
        brd = interior();
        n_checks++;
        if (obs() !== expv(0, 1, 2'b10, el + 1, er, 0))
            $display("FAIL hold_entry: got %b want %b", obs(), expv(0, 1, 2'b10, el + 1, er, 0));
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== expv(0, 0, 2'b00, 0, 0, 0))
            $display("FAIL reset_mid_hold: got %b want %b", obs(), expv(0, 0, 2'b00, 0, 0, 0));
        else n_pass++;
        el = 0;
        er = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs() !== expv(0, 0, 2'b00, 0, 0, 0))
            $display("FAIL after_reset_release: got %b want %b", obs(), expv(0, 0, 2'b00, 0, 0, 0));
        else n_pass++;
    endtask

`ifdef TOW_REFEREE_SEG_EN
    task automatic test_seg();
        for (int rnd = 0; rnd < 10; rnd++) begin
            brd = (rnd < 3) ? 16'h8000 : 16'h0001;
            @(negedge clk);
            brd = 16'h0100;
            if (rnd == 2) begin
                n_checks++;
                if (hex_left !== 7'b0100100)
                    $display("FAIL hex_left_lag: got %b want %b", hex_left, 7'b0100100);
                else n_pass++;
                @(negedge clk);
                n_checks++;
                if (hex_left !== 7'b0110000)
                    $display("FAIL hex_left_3: got %b want %b", hex_left, 7'b0110000);
                else n_pass++;
                repeat (HOLDC) @(negedge clk);
            end else begin
                repeat (HOLDC + 1) @(negedge clk);
            end
        end
        n_checks++;
        if ({match_over, hex_left, hex_right} !== {1'b1, 7'h7F, 7'b1111000})
            $display("FAIL hex_over: got %b want %b", {match_over, hex_left, hex_right},
                     {1'b1, 7'h7F, 7'b1111000});
        else n_pass++;
        new_match = 1'b1;
        @(negedge clk);
        new_match = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_rounds();
        test_reset_mid_hold();
`ifdef TOW_REFEREE_SEG_EN
        test_seg();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
